alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; the legal range is 4..64.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port in_valid, input, 1 bit: the upstream operation is valid.
REQ-005 Port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-006 Port in_op, input, alu_op_t (3 bits): operation select.
REQ-007 Port in_a and port in_b, input, WIDTH bits each: the operands.
REQ-008 Port out_valid, output, 1 bit: out_result and out_flags are valid.
REQ-009 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 Port out_result, output, WIDTH bits: the operation result.
REQ-011 Port out_flags, output, alu_flags_t (4 bits): {carry, overflow, negative, zero}.

Function
REQ-012 Ops SHALL be: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6 (logical), SRA=7 (arithmetic).
REQ-013 ADD/SUB SHALL compute modulo 2^WIDTH; carry = carry-out for ADD and borrow (a<b unsigned) for SUB.
REQ-014 Overflow SHALL be two's-complement signed overflow for ADD/SUB and 0 for all other ops.
REQ-015 Shifts SHALL use b[$clog2(WIDTH)-1:0] as the amount; carry = last bit shifted out, or 0 when the amount is 0.
REQ-016 Logic ops SHALL set carry=0; zero = (result==0) and negative = result MSB for every op.
REQ-017 A transfer SHALL occur on a cycle with in_valid && in_ready; the output handshake is out_valid && out_ready.
REQ-018 The datapath SHALL be two register stages: S1 registers the operands and op; S2 registers the result and flags. Latency is exactly 2 cycles from acceptance to out_valid under no stall.
REQ-019 Each stage SHALL advance when it is empty or the next stage advances; S2 advances when !out_valid || out_ready.
REQ-020 in_ready SHALL be 1 iff S1 is empty or S1 advances this cycle; it is combinational from out_ready with no combinational path from in_valid.
REQ-021 While out_valid && !out_ready, out_result and out_flags SHALL hold stable.
REQ-022 Sustained throughput SHALL be 1 op/cycle; at most 2 ops are in flight.
REQ-023 Results SHALL leave in acceptance order; none is dropped or duplicated.

Reset
REQ-024 rst SHALL clear both stage-valid bits immediately; out_valid=0, out_result=0, out_flags=0.
REQ-025 in_ready SHALL be 1 while rst is low and the pipeline is empty; in_ready is 0 while rst=1.
REQ-026 Operations in flight at reset SHALL be discarded; none emerges after rst deasserts.

Structure
REQ-027 Package alu_pkg SHALL hold alu_op_t (3-bit enum), alu_flags_t (packed struct, 4 bits) and the flag bit-index constants.
REQ-028 Combinational op evaluation SHALL live in sub-module alu_core (parameter WIDTH, ports a, b, op, result, flags); alu_pipe holds the pipeline registers and handshake.

Verification (WIDTH=8)
REQ-029 ADD 0xFF+0x01, out_ready=1 -> exactly 2 cycles later out_valid=1, result 0x00, carry=1, zero=1, overflow=0, negative=0.
REQ-030 ADD 0x7F+0x01 -> result 0x80, overflow=1, negative=1, carry=0; SUB 0x00-0x01 -> result 0xFF, carry=1, negative=1.
REQ-031 SRA 0x81 by b=0x01 -> result 0xC0, carry=1; SHL 0x81 by b=0x09 (amount 1) -> result 0x02, carry=1.
REQ-032 Issue 3 back-to-back ops with out_ready=0 -> 2 accepted, in_ready=0 on the third, output stable; raise out_ready -> all 3 results in order on consecutive cycles.
REQ-033 Assert rst with 2 ops in flight -> out_valid=0 at once; after release no stale result appears and a new op returns in 2 cycles.
REQ-034 Exhaustive random sweep of all ops against a reference model with random out_ready stalls -> zero mismatches and zero lost or duplicated results.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU pipeline shared types.
// Op encoding, flag bundle and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_SRA = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_CARRY = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU evaluation.
// Result and {carry, overflow, negative, zero}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]  w_amt;
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_shr;
  logic [WIDTH:0] w_sra;
  logic           w_carry;
  logic           w_ovf;

  assign w_amt = b[SW-1:0];
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  // Extra bit beside the operand catches the last bit shifted out
  assign w_shl = {1'b0, a} << w_amt;
  assign w_shr = {a, 1'b0} >> w_amt;
  assign w_sra = $signed({a, 1'b0}) >>> w_amt;

  always_comb begin
    result  = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin
        result  = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result  = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result  = w_shl[WIDTH-1:0];
        w_carry = w_shl[WIDTH];
      end
      OP_SHR: begin
        result  = w_shr[WIDTH:1];
        w_carry = w_shr[0];
      end
      OP_SRA: begin
        result  = w_sra[WIDTH:1];
        w_carry = w_sra[0];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    flags          = '0;
    flags.carry    = w_carry;
    flags.overflow = w_ovf;
    flags.negative = result[WIDTH-1];
    flags.zero     = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshake.
// S1 holds operands, S2 holds result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output alu_flags_t       out_flags
);

  logic             r_s1_valid;
  alu_op_t          r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  alu_flags_t       r_s2_flags;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_result;
  alu_flags_t       w_flags;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = !rst && w_s1_adv;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (r_s1_a),
    .b      (r_s1_b),
    .op     (r_s1_op),
    .result (w_result),
    .flags  (w_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= in_op;
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_result;
        r_s2_flags  <= w_flags;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_flags  = r_s2_flags;

endmodule
